// File: rtl/regfile_wport_arbiter_if.sv
// Bundles the requester, register-file write-port and hazard-query signals of the
// write-port arbiter. The arbiter uses slave; requesters and query logic use master.
interface regfile_wport_arbiter_if #(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   we;
  logic [ADDR_W-1:0]      waddr;
  logic [DATA_W-1:0]      wdata;
  logic [ADDR_W-1:0]      qaddr1;
  logic                   qbusy1;
  logic [ADDR_W-1:0]      qaddr2;
  logic                   qbusy2;
  logic [15:0]            grant_cnt;

  modport master (
    output req_valid, req_addr, req_data, qaddr1, qaddr2,
    input  req_ready, we, waddr, wdata, qbusy1, qbusy2, grant_cnt
  );

  modport slave (
    input  req_valid, req_addr, req_data, qaddr1, qaddr2,
    output req_ready, we, waddr, wdata, qbusy1, qbusy2, grant_cnt
  );
endinterface

// File: rtl/regfile_wport_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NREQ requesters,
// with a registered write stage and combinational pending-write hazard queries.
module regfile_wport_arbiter #(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input logic                    clk,
  input logic                    rst,
  regfile_wport_arbiter_if.slave bus
);
  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0]  r_rr_ptr;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [15:0]       r_grant_cnt;

  logic [NREQ-1:0]   w_ready;
  logic              w_xfer;
  logic [PTR_W-1:0]  w_gidx;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic [ADDR_W-1:0] w_gaddr;
  logic [DATA_W-1:0] w_gdata;
  logic              w_pend1;
  logic              w_pend2;

  // First valid requester at or after rr_ptr wins; reset suppresses any grant.
  always_comb begin
    int unsigned idx;
    w_ready = '0;
    w_xfer  = 1'b0;
    w_gidx  = '0;
    idx     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(r_rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_xfer && bus.req_valid[idx]) begin
        w_ready[idx] = 1'b1;
        w_xfer       = 1'b1;
        w_gidx       = PTR_W'(idx);
      end
    end
    if (rst) begin
      w_ready = '0;
      w_xfer  = 1'b0;
    end
  end

  always_comb begin
    w_gaddr   = bus.req_addr[32'(w_gidx) * ADDR_W +: ADDR_W];
    w_gdata   = bus.req_data[32'(w_gidx) * DATA_W +: DATA_W];
    w_ptr_nxt = (32'(w_gidx) == NREQ - 1) ? '0 : w_gidx + PTR_W'(1);
  end

  // Only requests still waiting count; the granted one is covered by write-through.
  always_comb begin
    w_pend1 = 1'b0;
    w_pend2 = 1'b0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (bus.req_valid[j] && !w_ready[j]) begin
        if (bus.req_addr[j*ADDR_W +: ADDR_W] == bus.qaddr1) w_pend1 = 1'b1;
        if (bus.req_addr[j*ADDR_W +: ADDR_W] == bus.qaddr2) w_pend2 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_grant_cnt <= '0;
    end else begin
      // Address-0 grants complete the handshake but never write.
      r_we <= w_xfer && (w_gaddr != '0);
      if (w_xfer) begin
        r_rr_ptr    <= w_ptr_nxt;
        r_waddr     <= w_gaddr;
        r_wdata     <= w_gdata;
        r_grant_cnt <= r_grant_cnt + 16'd1;
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.we        = r_we;
  assign bus.waddr     = r_waddr;
  assign bus.wdata     = r_wdata;
  assign bus.grant_cnt = r_grant_cnt;
  assign bus.qbusy1    = !rst && (bus.qaddr1 != '0) && w_pend1;
  assign bus.qbusy2    = !rst && (bus.qaddr2 != '0) && w_pend2;
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench for regfile_wport_arbiter: a cycle-by-cycle vector table plus
// hand-written reset-during-grant and grant-counter wrap sequences.
module tb_regfile_wport_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wport_arbiter_if #(.NREQ(3), .ADDR_W(5), .DATA_W(32)) bus ();

  regfile_wport_arbiter #(.NREQ(3), .ADDR_W(5), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst;
    logic [2:0]  valid;
    logic [14:0] addr;
    logic [95:0] data;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic [2:0]  ready;
    logic        qb1;
    logic        qb2;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [15:0] cnt;
    logic        cwd;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic [2:0] v,
    input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
    input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
    input logic [4:0] q1, input logic [4:0] q2,
    input logic [2:0] rdy, input logic qb1, input logic qb2,
    input logic we, input logic [4:0] wa, input logic [31:0] wd,
    input logic [15:0] cnt, input logic cwd);
    vec_t t;
    t.rst = r;     t.valid = v;
    t.addr = {a2, a1, a0};
    t.data = {d2, d1, d0};
    t.q1 = q1;     t.q2 = q2;
    t.ready = rdy; t.qb1 = qb1; t.qb2 = qb2;
    t.we = we;     t.waddr = wa; t.wdata = wd;
    t.cnt = cnt;   t.cwd = cwd;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  vec_t tv [20];

  initial begin
    // Registered columns show the effect of the previous row's clock edge.
    tv[0]  = mk(1, 3'b111, 1, 2, 3, 'hA0, 'hA1, 'hA2, 1, 2, 3'b000, 0, 0, 0, 0, 0, 0, 1);
    tv[1]  = mk(0, 3'b010, 0, 5, 0, 0, 'hDEADBEEF, 0, 5, 0, 3'b010, 0, 0, 0, 0, 0, 0, 1);
    tv[2]  = mk(0, 3'b000, 0, 5, 0, 0, 'hDEADBEEF, 0, 5, 0, 3'b000, 0, 0,
                1, 5, 'hDEADBEEF, 1, 1);
    tv[3]  = mk(0, 3'b000, 0, 5, 0, 0, 'hDEADBEEF, 0, 5, 0, 3'b000, 0, 0,
                0, 5, 'hDEADBEEF, 1, 1);
    tv[4]  = mk(0, 3'b111, 1, 2, 3, 'hA0, 'hA1, 'hA2, 1, 3, 3'b100, 1, 0,
                0, 5, 'hDEADBEEF, 1, 1);
    tv[5]  = mk(1, 3'b111, 1, 2, 3, 'hA0, 'hA1, 'hA2, 1, 3, 3'b000, 0, 0, 1, 3, 'hA2, 2, 1);
    tv[6]  = mk(0, 3'b111, 1, 2, 3, 'hA0, 'hA1, 'hA2, 2, 1, 3'b001, 1, 0, 0, 0, 0, 0, 1);
    tv[7]  = mk(0, 3'b111, 1, 2, 3, 'hA0, 'hA1, 'hA2, 2, 1, 3'b010, 0, 1, 1, 1, 'hA0, 1, 1);
    tv[8]  = mk(0, 3'b111, 1, 2, 3, 'hA0, 'hA1, 'hA2, 2, 1, 3'b100, 1, 1, 1, 2, 'hA1, 2, 1);
    tv[9]  = mk(0, 3'b111, 1, 2, 3, 'hA0, 'hA1, 'hA2, 2, 1, 3'b001, 1, 0, 1, 3, 'hA2, 3, 1);
    tv[10] = mk(0, 3'b111, 1, 2, 3, 'hA0, 'hA1, 'hA2, 2, 1, 3'b010, 0, 1, 1, 1, 'hA0, 4, 1);
    tv[11] = mk(0, 3'b111, 1, 2, 3, 'hA0, 'hA1, 'hA2, 2, 1, 3'b100, 1, 1, 1, 2, 'hA1, 5, 1);
    tv[12] = mk(0, 3'b000, 1, 2, 3, 'hA0, 'hA1, 'hA2, 2, 1, 3'b000, 0, 0, 1, 3, 'hA2, 6, 1);
    tv[13] = mk(0, 3'b001, 9, 0, 0, 'h33, 0, 0, 7, 9, 3'b001, 0, 0, 0, 3, 'hA2, 6, 1);
    tv[14] = mk(0, 3'b101, 7, 0, 7, 'h11, 0, 'h22, 7, 0, 3'b100, 1, 0, 1, 9, 'h33, 7, 1);
    tv[15] = mk(0, 3'b001, 7, 0, 7, 'h11, 0, 'h22, 7, 0, 3'b001, 0, 0, 1, 7, 'h22, 8, 1);
    tv[16] = mk(0, 3'b000, 7, 0, 7, 'h11, 0, 'h22, 7, 0, 3'b000, 0, 0, 1, 7, 'h11, 9, 1);
    tv[17] = mk(0, 3'b011, 0, 4, 0, 'hFFFFFFFF, 'h44, 0, 0, 4, 3'b010, 0, 0,
                0, 7, 'h11, 9, 1);
    tv[18] = mk(0, 3'b001, 0, 4, 0, 'hFFFFFFFF, 'h44, 0, 0, 4, 3'b001, 0, 0,
                1, 4, 'h44, 10, 1);
    tv[19] = mk(0, 3'b000, 0, 4, 0, 'hFFFFFFFF, 'h44, 0, 0, 4, 3'b000, 0, 0, 0, 0, 0, 11, 0);

    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.qaddr1    = '0;
    bus.qaddr2    = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) begin
      rst           = tv[i].rst;
      bus.req_valid = tv[i].valid;
      bus.req_addr  = tv[i].addr;
      bus.req_data  = tv[i].data;
      bus.qaddr1    = tv[i].q1;
      bus.qaddr2    = tv[i].q2;
      #3;
      chk($sformatf("v%0d req_ready", i), 32'(bus.req_ready), 32'(tv[i].ready));
      chk($sformatf("v%0d qbusy1", i), 32'(bus.qbusy1), 32'(tv[i].qb1));
      chk($sformatf("v%0d qbusy2", i), 32'(bus.qbusy2), 32'(tv[i].qb2));
      chk($sformatf("v%0d we", i), 32'(bus.we), 32'(tv[i].we));
      chk($sformatf("v%0d grant_cnt", i), 32'(bus.grant_cnt), 32'(tv[i].cnt));
      if (tv[i].cwd) begin
        chk($sformatf("v%0d waddr", i), 32'(bus.waddr), 32'(tv[i].waddr));
        chk($sformatf("v%0d wdata", i), bus.wdata, tv[i].wdata);
      end
      @(posedge clk);
      #1;
    end

    // Reset asserted in the same cycle requester 1 would be granted.
    rst           = 1'b0;
    bus.req_valid = 3'b010;
    bus.req_addr  = {5'd0, 5'd6, 5'd0};
    bus.req_data  = {32'd0, 32'h0000_0066, 32'd0};
    bus.qaddr1    = 5'd6;
    bus.qaddr2    = 5'd0;
    #3;
    chk("rst_mid ready_before", 32'(bus.req_ready), 32'b010);
    rst = 1'b1;
    #1;
    chk("rst_mid ready_in_rst", 32'(bus.req_ready), 32'b000);
    @(posedge clk);
    #4;
    chk("rst_mid we", 32'(bus.we), 32'd0);
    chk("rst_mid grant_cnt", 32'(bus.grant_cnt), 32'd0);
    chk("rst_mid ready", 32'(bus.req_ready), 32'b000);
    chk("rst_mid qbusy1", 32'(bus.qbusy1), 32'd0);
    rst           = 1'b0;
    bus.req_valid = 3'b111;
    bus.req_addr  = {5'd3, 5'd2, 5'd1};
    #1;
    chk("rst_mid rr_ptr0", 32'(bus.req_ready), 32'b001);

    // Continuous traffic: one transfer per cycle drives grant_cnt to the wrap point.
    repeat (65535) @(posedge clk);
    #4;
    chk("wrap cnt_ffff", 32'(bus.grant_cnt), 32'h0000_FFFF);
    chk("wrap pending", 32'(bus.req_ready != 3'b000), 32'd1);
    @(posedge clk);
    #4;
    chk("wrap cnt_0000", 32'(bus.grant_cnt), 32'h0000_0000);
    chk("wrap we", 32'(bus.we), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
